// File: rtl/wb_sk6812_rx_pkg.sv
// Shared definitions for the SK6812 receive block: register map, bit indices
// and the bit-decoder state encoding.
package wb_sk6812_rx_pkg;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_FDONE  = 3;
  localparam int ST_PART   = 4;
  localparam int ST_CNT_LO = 8;

  localparam int CT_EN       = 0;
  localparam int CT_IE_DATA  = 1;
  localparam int CT_IE_FRAME = 2;
  localparam int CT_FLUSH    = 8;
  localparam int CT_CLR_OVF  = 9;
  localparam int CT_CLR_FD   = 10;
  localparam int CT_CLR_PART = 11;

  typedef enum logic [1:0] {DEC_IDLE, DEC_HIGH, DEC_LOW} dec_state_t;
endpackage

// File: rtl/wb_sk6812_rx_if.sv
// Wishbone classic bus bundle between the LM32 conbus and the SK6812 receiver.
interface wb_sk6812_rx_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_sk6812_rx_bit_decoder.sv
// Synchronizes the SK6812 line, measures high/low pulse widths and assembles
// 32-bit GRBW words MSB-first; flags frame ends and truncated frames.
module sk6812_bit_decoder
  import wb_sk6812_rx_pkg::*;
#(
  parameter int thresh_cycles   = 22,
  parameter int min_high_cycles = 4,
  parameter int gap_cycles      = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        led_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        frame_end,
  output logic        partial_err
);
  localparam int LW = $clog2(gap_cycles + 1);
  localparam logic [7:0]    THR  = 8'(thresh_cycles);
  localparam logic [7:0]    MINH = 8'(min_high_cycles);
  // lcnt misses the falling-edge cycle and the current cycle, hence the -2
  localparam logic [LW-1:0] GAP_END = LW'(gap_cycles - 2);

  logic [2:0]    sync;
  dec_state_t    state, state_n;
  logic [7:0]    hcnt, hcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [31:0]   sreg, sreg_n;
  logic [5:0]    bitcnt, bitcnt_n;
  logic          rise, fall;

  assign rise       = sync[1] & ~sync[2];
  assign fall       = ~sync[1] & sync[2];
  assign word_valid = (bitcnt == 6'd32);
  assign word       = sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      state  <= DEC_IDLE;
      hcnt   <= '0;
      lcnt   <= '0;
      sreg   <= '0;
      bitcnt <= '0;
    end else begin
      sync   <= {sync[1:0], led_in};
      state  <= state_n;
      hcnt   <= hcnt_n;
      lcnt   <= lcnt_n;
      sreg   <= sreg_n;
      bitcnt <= bitcnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    hcnt_n      = hcnt;
    lcnt_n      = lcnt;
    sreg_n      = sreg;
    bitcnt_n    = word_valid ? 6'd0 : bitcnt;
    frame_end   = 1'b0;
    partial_err = 1'b0;
    if (!enable) begin
      state_n  = DEC_IDLE;
      bitcnt_n = 6'd0;
    end else begin
      unique case (state)
        DEC_IDLE: if (rise) begin
          state_n = DEC_HIGH;
          hcnt_n  = 8'd1;
        end
        DEC_HIGH: begin
          if (hcnt != 8'hFF) hcnt_n = hcnt + 8'd1;
          if (fall) begin
            state_n = DEC_LOW;
            // short pulses are glitches: dropped, low timing continues
            if (hcnt >= MINH) begin
              sreg_n   = {sreg[30:0], hcnt >= THR};
              bitcnt_n = bitcnt_n + 6'd1;
              lcnt_n   = '0;
            end
          end
        end
        DEC_LOW: begin
          if (rise) begin
            state_n = DEC_HIGH;
            hcnt_n  = 8'd1;
          end else if (lcnt == GAP_END) begin
            frame_end   = 1'b1;
            partial_err = (bitcnt_n != 6'd0);
            bitcnt_n    = 6'd0;
            sreg_n      = '0;
            state_n     = DEC_IDLE;
          end else begin
            lcnt_n = lcnt + LW'(1);
          end
        end
        default: state_n = DEC_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/wb_sk6812_rx.sv
// Wishbone slave that buffers decoded SK6812 GRBW words in a FIFO and reports
// frame/overflow/partial status with a level interrupt.
module wb_sk6812_rx
  import wb_sk6812_rx_pkg::*;
#(
  parameter int clk_freq        = 50000000,
  parameter int thresh_cycles   = 22,
  parameter int min_high_cycles = 4,
  parameter int gap_cycles      = 2500,
  parameter int fifo_aw         = 4
) (
  input  logic           clk,
  input  logic           rst,
  wb_sk6812_rx_if.slave  wb,
  input  logic           led_in,
  output logic           intr
);
  localparam int AW    = fifo_aw;
  localparam int DEPTH = 2 ** fifo_aw;

  logic          word_valid, frame_end, partial_err;
  logic [31:0]   word;
  logic          enable, ie_data, ie_frame;
  logic          overflow, frame_done, partial;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, req, wr_ctrl, do_pop, do_push, flush;
  logic [1:0]    sel;
  logic [31:0]   rdata, status;
  logic          unused_ok;

  sk6812_bit_decoder #(
    .thresh_cycles(thresh_cycles), .min_high_cycles(min_high_cycles), .gap_cycles(gap_cycles)
  ) u_dec (
    .clk(clk), .rst(rst), .enable(enable), .led_in(led_in),
    .word_valid(word_valid), .word(word), .frame_end(frame_end), .partial_err(partial_err)
  );

  assign unused_ok = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_sel_i,
                       wb.wb_dat_i[31:12], wb.wb_dat_i[7:3], clk_freq > 0};

  assign sel     = wb.wb_adr_i[3:2];
  assign req     = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr_ctrl = req & wb.wb_we_i & (sel == REG_CTRL);
  assign flush   = wr_ctrl & wb.wb_dat_i[CT_FLUSH];
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = req & ~wb.wb_we_i & (sel == REG_DATA) & ~empty;
  // a full FIFO still accepts a word when the same cycle pops one
  assign do_push = word_valid & (~full | do_pop);
  assign intr    = (frame_done & ie_frame) | (~empty & ie_data);

  always_comb begin
    status                        = '0;
    status[ST_EMPTY]              = empty;
    status[ST_FULL]               = full;
    status[ST_OVF]                = overflow;
    status[ST_FDONE]              = frame_done;
    status[ST_PART]               = partial;
    status[ST_CNT_LO +: AW+1]     = count;
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      REG_STATUS: rdata = status;
      REG_DATA:   rdata = empty ? '0 : mem[rd_ptr];
      REG_CTRL:   rdata = {29'd0, ie_frame, ie_data, enable};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      enable      <= 1'b0;
      ie_data     <= 1'b0;
      ie_frame    <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      partial     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= (req && !wb.wb_we_i) ? rdata : '0;
      if (wr_ctrl) begin
        enable   <= wb.wb_dat_i[CT_EN];
        ie_data  <= wb.wb_dat_i[CT_IE_DATA];
        ie_frame <= wb.wb_dat_i[CT_IE_FRAME];
      end
      // sticky sets take priority over a same-cycle clear
      overflow   <= (word_valid & full & ~do_pop) | (overflow & ~(wr_ctrl & wb.wb_dat_i[CT_CLR_OVF]));
      frame_done <= frame_end | (frame_done & ~(wr_ctrl & wb.wb_dat_i[CT_CLR_FD]));
      partial    <= partial_err | (partial & ~(wr_ctrl & wb.wb_dat_i[CT_CLR_PART]));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({do_push, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_sk6812_rx.sv
// Directed bench for wb_sk6812_rx: drives SK6812 pulse trains and Wishbone
// accesses, checking against a pulse-rule model of words, FIFO and flags.
module tb_wb_sk6812_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_in = 1'b0;
  logic intr;

  wb_sk6812_rx_if bus();

  wb_sk6812_rx dut (.clk(clk), .rst(rst), .wb(bus), .led_in(led_in), .intr(intr));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, intr_prints = 0;

  // model state
  logic [31:0] mq[$];
  logic [31:0] m_sreg = '0;
  int          m_bits = 0;
  bit m_ovf, m_fd, m_part, m_en, m_ied, m_ief;

  bit quiet = 1'b0, exp_valid = 1'b0, bus_busy = 1'b0;
  logic [31:0] exp_dat = '0;
  string exp_name = "";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0]    = (mq.size() == 0);
    s[1]    = (mq.size() == 16);
    s[2]    = m_ovf;
    s[3]    = m_fd;
    s[4]    = m_part;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic m_intr();
    return (m_fd & m_ief) | ((mq.size() != 0) & m_ied);
  endfunction

  // one high pulse of h clocks: glitches vanish, else width decides the bit
  task automatic m_pulse(input int h);
    if (!m_en || h < 4) return;
    m_sreg = {m_sreg[30:0], h >= 22};
    m_bits++;
    if (m_bits == 32) begin
      if (mq.size() < 16) mq.push_back(m_sreg);
      else m_ovf = 1'b1;
      m_bits = 0;
    end
  endtask

  task automatic m_gap();
    m_fd = 1'b1;
    if (m_bits != 0) m_part = 1'b1;
    m_bits = 0;
  endtask

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'd0;
    return mq.pop_front();
  endfunction

  // compare process: read data on every ack, intr whenever the line is settled
  always @(negedge clk) begin
    if (bus.wb_ack_o) begin
      if (exp_valid) check(exp_name, bus.wb_dat_o, exp_dat);
      else if (!bus_busy) check("stray_ack", 32'(bus.wb_ack_o), 32'd0);
    end
    if (quiet) begin
      n_chk++;
      if (intr === m_intr()) n_pass++;
      else if (intr_prints < 5) begin
        intr_prints++;
        $display("FAIL intr: got %b, want %b", intr, m_intr());
      end
    end
  end

  // all stimulus tasks start and end just after a rising edge
  task automatic pulse(input int h, input int l);
    led_in = 1'b1;
    repeat (h) @(posedge clk);
    #1 led_in = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int h1, input int h0,
                           input int last_low, input int glitch_bit);
    int h, l;
    quiet = 1'b0;
    for (int j = n - 1; j >= 0; j--) begin
      h = w[j] ? h1 : h0;
      l = (j == 0 && last_low > 0) ? last_low : 62 - h;
      if (glitch_bit == j) begin
        pulse(h, 20);
        pulse(2, l - 22);
        m_pulse(h);
        m_pulse(2);
      end else begin
        pulse(h, l);
        m_pulse(h);
      end
    end
    if (last_low >= 2500) begin
      m_gap();
      repeat (5) @(posedge clk);
      #1 quiet = 1'b1;
    end
  endtask

  task automatic wb_access(input logic [1:0] r, input bit we, input logic [31:0] d,
                           input string name, input logic [31:0] exp);
    bit got = 1'b0;
    bit saved = quiet;
    if (we || r == 2'd1) quiet = 1'b0;
    bus_busy = 1'b1;
    exp_valid = !we;
    exp_dat = exp;
    exp_name = name;
    bus.wb_adr_i = {28'd0, r, 2'b00};
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) got = 1'b1;
    end
    if (!got) check({name, "_ack_timeout"}, 32'd0, 32'd1);
    if (we && r == 2'd2) begin
      m_en = d[0]; m_ied = d[1]; m_ief = d[2];
      if (d[8])  mq.delete();
      if (d[9])  m_ovf = 1'b0;
      if (d[10]) m_fd = 1'b0;
      if (d[11]) m_part = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    bus_busy = 1'b0;
    quiet = saved;
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    wb_access(2'd2, 1'b1, d, "ctrl_wr", 32'd0);
  endtask

  task automatic rd_status(input string name);
    wb_access(2'd0, 1'b0, 32'd0, name, m_status());
  endtask

  task automatic rd_data(input string name);
    wb_access(2'd1, 1'b0, 32'd0, name, m_pop());
  endtask

  function automatic logic [31:0] wgen(input int i);
    return {8'(i + 1), 8'(8'hF0 - i), 8'(i * 7), 8'hA5 ^ 8'(i)};
  endfunction

  logic [31:0] w;

  initial begin
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("pin_status_reset", m_status(), 32'h0000_0001);
    wb_access(2'd0, 1'b0, 32'd0, "status_reset", 32'h0000_0001);
    quiet = 1'b1;

    // single word, then frame gap
    wr_ctrl(32'h1);
    send_bits(32'hA5C3_0FF0, 32, 30, 15, 3000, -1);
    check("pin_status_one", m_status(), 32'h0000_0108);
    rd_status("status_one");
    wb_access(2'd1, 1'b0, 32'd0, "data_one", 32'hA5C3_0FF0);
    check("pin_model_one", m_pop(), 32'hA5C3_0FF0);
    rd_status("status_after_pop");
    wr_ctrl(32'h401);

    // fill to 16, then one more word overflows
    for (int i = 0; i < 16; i++) send_bits(wgen(i), 32, 30, 15, (i == 15) ? 3000 : 0, -1);
    check("pin_status_full", m_status(), 32'h0000_100A);
    rd_status("status_full");
    wr_ctrl(32'h401);
    send_bits(wgen(16), 32, 30, 15, 3000, -1);
    check("pin_status_ovf", m_status(), 32'h0000_100E);
    rd_status("status_ovf");
    wb_access(2'd1, 1'b0, 32'd0, "drain_first", 32'h01F0_00A5);
    check("pin_model_first", m_pop(), 32'h01F0_00A5);
    for (int i = 1; i < 17; i++) rd_data($sformatf("drain_%0d", i));
    rd_status("status_drained");
    wr_ctrl(32'h601);

    // truncated frame
    send_bits(32'h000A_BCDE, 20, 30, 15, 3000, -1);
    check("pin_status_partial", m_status(), 32'h0000_0019);
    rd_status("status_partial");
    wr_ctrl(32'h0C01);
    wb_access(2'd0, 1'b0, 32'd0, "status_cleared", 32'h0000_0001);
    wb_access(2'd2, 1'b0, 32'd0, "ctrl_readback", 32'h0000_0001);

    // glitch inside a low period
    send_bits(32'h1234_5678, 32, 30, 15, 3000, 5);
    rd_status("status_glitch");
    wb_access(2'd1, 1'b0, 32'd0, "data_glitch", 32'h1234_5678);
    check("pin_model_glitch", m_pop(), 32'h1234_5678);
    wr_ctrl(32'h401);

    // 21 vs 22 clock highs
    send_bits(32'h5A3C_96E1, 32, 22, 21, 3000, -1);
    rd_status("status_thresh");
    wb_access(2'd1, 1'b0, 32'd0, "data_thresh", 32'h5A3C_96E1);
    check("pin_model_thresh", m_pop(), 32'h5A3C_96E1);
    wr_ctrl(32'h401);

    // 2499-clock low keeps the frame open
    w = 32'hC0FF_EE11;
    send_bits({31'd0, w[31]}, 1, 30, 15, 2499, -1);
    send_bits(w, 31, 30, 15, 3000, -1);
    check("pin_status_2499", m_status(), 32'h0000_0108);
    rd_status("status_2499");
    wb_access(2'd1, 1'b0, 32'd0, "data_2499", 32'hC0FF_EE11);
    check("pin_model_2499", m_pop(), 32'hC0FF_EE11);
    wr_ctrl(32'h401);

    // 2500-clock low ends it
    send_bits(32'h1, 1, 30, 15, 2500, -1);
    check("pin_status_2500", m_status(), 32'h0000_0019);
    rd_status("status_2500");
    wr_ctrl(32'h0C01);

    // data interrupt, then reset mid-word
    wr_ctrl(32'h3);
    send_bits(32'h0F1E_2D3C, 32, 30, 15, 3000, -1);
    @(negedge clk);
    check("intr_data", 32'(intr), 32'd1);
    @(posedge clk);
    #1;
    send_bits(32'h0000_ABCD, 16, 30, 15, 0, -1);
    rst = 1'b0;
    led_in = 1'b0;
    @(negedge clk);
    check("rstmid_intr", 32'(intr), 32'd0);
    check("rstmid_ack", 32'(bus.wb_ack_o), 32'd0);
    mq.delete();
    m_bits = 0; m_sreg = '0;
    m_ovf = 0; m_fd = 0; m_part = 0; m_en = 0; m_ied = 0; m_ief = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 quiet = 1'b1;
    wb_access(2'd0, 1'b0, 32'd0, "status_post_rst", 32'h0000_0001);
    rd_data("data_post_rst");

    quiet = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule
